mem_arbiter: RTL

Arbitrates a single shared main-memory port between the instruction-fetch side and the data-memory side of the five-stage pipeline. Sits between the fetch stage, the memory stage and the external memory. Sequences one transaction at a time through a small FSM, returns a one-cycle acknowledge with read data to the winner, and exposes per-side stall signals. A bounded-wait counter aborts hung transactions with an error flag.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_wait_counter.sv | 31 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  localparam int unsigned DATA_W = 32;

  // Bits needed to hold 0..max_wait inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating wait counter; tc_o flags the cycle whose edge brings the count to MAX_WAIT.
module mem_arbiter_wait_counter #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned W        = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] MAX = W'(MAX_WAIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Lookahead so the abort lands on the MAX_WAIT-th busy cycle, not one later.
  assign tc_o = en_i & (cnt_d == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data sides, one transaction at a time,
// with a bounded wait that aborts hung accesses and flags err with the ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CW = cnt_w(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic              side_q, side_d;    // 1 = data side owns the transaction
  logic              abort_q, abort_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_byte_q, mem_byte_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              cnt_en, cnt_clr, cnt_tc, done;

  assign cnt_en  = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  assign cnt_clr = ~cnt_en;

  mem_arbiter_wait_counter #(.MAX_WAIT(MAX_WAIT), .W(CW)) u_wait (
    .clock (clock),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    abort_d     = abort_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        // Data wins ties: the memory stage holds the older instruction.
        if (d_req) begin
          state_d     = ARB_BUSY_D;
          side_d      = 1'b1;
          abort_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_byte_d  = d_byte;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req) begin
          state_d     = ARB_BUSY_I;
          side_d      = 1'b0;
          abort_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_byte_d  = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready) begin
          state_d   = ARB_DONE;
          mem_req_d = 1'b0;
          if (side_q) d_rdata_d = mem_we_q ? '0 : mem_rdata;
          else        i_rdata_d = mem_rdata;
        end else if (cnt_tc) begin
          state_d   = ARB_DONE;
          mem_req_d = 1'b0;
          abort_d   = 1'b1;
          if (side_q) d_rdata_d = '0;
          else        i_rdata_d = '0;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      side_q      <= 1'b0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      abort_q     <= abort_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign done      = (state_q == ARB_DONE);
  assign i_ack     = done & ~side_q;
  assign d_ack     = done & side_q;
  assign err       = done & abort_q;
  assign i_stall   = i_req & ~i_ack;
  assign d_stall   = d_req & ~d_ack;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
